// File: rtl/coherence_pkg.sv
// rtl/coherence_pkg.sv - MSI state, bus message, action and emitter op codes shared by snoop and emitter
package coherence_pkg;

  typedef enum logic [1:0] {
    ST_INVALID  = 2'd0,
    ST_SHARED   = 2'd1,
    ST_MODIFIED = 2'd2
  } line_state_e;

  typedef enum logic [1:0] {
    MSG_NONE       = 2'd0,
    MSG_READ_MISS  = 2'd1,
    MSG_WRITE_MISS = 2'd2,
    MSG_INVALIDATE = 2'd3
  } bus_msg_e;

  typedef enum logic [1:0] {
    ACT_NONE      = 2'd0,
    ACT_WRITEBACK = 2'd1,
    ACT_ABORT     = 2'd2
  } action_e;

  // Emitter-side operation codes: read/write miss or hit.
  typedef enum logic [1:0] {
    OP_RM = 2'd0,
    OP_RH = 2'd1,
    OP_WM = 2'd2,
    OP_WH = 2'd3
  } emit_op_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOOKUP  = 2'd1,
    S_RESPOND = 2'd2
  } snoop_fsm_e;

endpackage

// File: rtl/snoop_line_store.sv
// rtl/snoop_line_store.sv - direct-mapped tag/state/data store, local install wins over snoop update
module snoop_line_store
  import coherence_pkg::*;
#(
  parameter int NUM_LINES = 4,
  parameter int TAG_W     = 4,
  parameter int DATA_W    = 8,
  localparam int IDX_W    = $clog2(NUM_LINES)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [TAG_W-1:0]  rd_tag_o,
  output line_state_e       rd_state_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic [IDX_W-1:0]  probe_idx_i,
  output line_state_e       probe_state_o,
  input  logic              local_we_i,
  input  logic [IDX_W-1:0]  local_idx_i,
  input  logic [TAG_W-1:0]  local_tag_i,
  input  line_state_e       local_state_i,
  input  logic [DATA_W-1:0] local_data_i,
  input  logic              snoop_we_i,
  input  logic [IDX_W-1:0]  snoop_idx_i,
  input  line_state_e       snoop_state_i
);

  line_state_e       state_q [NUM_LINES];
  logic [TAG_W-1:0]  tag_q   [NUM_LINES];
  logic [DATA_W-1:0] data_q  [NUM_LINES];

  assign rd_tag_o      = tag_q[rd_idx_i];
  assign rd_state_o    = state_q[rd_idx_i];
  assign rd_data_o     = data_q[rd_idx_i];
  assign probe_state_o = state_q[probe_idx_i];

  // Snoop only ever changes the state field; tag and data belong to the local side.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        state_q[i] <= ST_INVALID;
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LINES; i++) begin
        if (local_we_i && (local_idx_i == IDX_W'(i))) begin
          state_q[i] <= local_state_i;
          tag_q[i]   <= local_tag_i;
          data_q[i]  <= local_data_i;
        end else if (snoop_we_i && (snoop_idx_i == IDX_W'(i))) begin
          state_q[i] <= snoop_state_i;
        end
      end
    end
  end

endmodule

// File: rtl/snoop_receiver.sv
// rtl/snoop_receiver.sv - MSI snoop-side controller: bus message lookup, downgrade/invalidate, write-back/abort action
module snoop_receiver
  import coherence_pkg::*;
#(
  parameter int NUM_LINES = 4,
  parameter int TAG_W     = 4,
  parameter int DATA_W    = 8,
  localparam int IDX_W    = $clog2(NUM_LINES),
  localparam int AW       = TAG_W + IDX_W
) (
  input  logic              i_Clock,
  input  logic              i_Reset_n,
  input  logic              i_Bus_Valid,
  input  logic [1:0]        i_Bus_Message,
  input  logic [AW-1:0]     i_Bus_Addr,
  output logic              o_Bus_Ready,
  input  logic              i_Local_Valid,
  input  logic [AW-1:0]     i_Local_Addr,
  input  logic [1:0]        i_Local_State,
  input  logic [DATA_W-1:0] i_Local_Data,
  output logic              o_Action_Valid,
  output logic [1:0]        o_Action,
  output logic [AW-1:0]     o_Wb_Addr,
  output logic [DATA_W-1:0] o_Wb_Data,
  input  logic              i_Action_Ack,
  input  logic [IDX_W-1:0]  i_Probe_Index,
  output logic [1:0]        o_Probe_State
);

  snoop_fsm_e        state_q, state_d;
  bus_msg_e          msg_q, msg_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              act_valid_q, act_valid_d;
  action_e           action_q, action_d;
  logic [AW-1:0]     wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  logic [TAG_W-1:0]  rd_tag;
  line_state_e       rd_state;
  logic [DATA_W-1:0] rd_data;
  line_state_e       probe_state;
  logic              snoop_we;
  line_state_e       snoop_state;
  logic              hit;

  snoop_line_store #(
    .NUM_LINES (NUM_LINES),
    .TAG_W     (TAG_W),
    .DATA_W    (DATA_W)
  ) u_store (
    .clk_i         (i_Clock),
    .rst_ni        (i_Reset_n),
    .rd_idx_i      (addr_q[IDX_W-1:0]),
    .rd_tag_o      (rd_tag),
    .rd_state_o    (rd_state),
    .rd_data_o     (rd_data),
    .probe_idx_i   (i_Probe_Index),
    .probe_state_o (probe_state),
    .local_we_i    (i_Local_Valid),
    .local_idx_i   (i_Local_Addr[IDX_W-1:0]),
    .local_tag_i   (i_Local_Addr[AW-1:IDX_W]),
    .local_state_i (line_state_e'(i_Local_State)),
    .local_data_i  (i_Local_Data),
    .snoop_we_i    (snoop_we),
    .snoop_idx_i   (addr_q[IDX_W-1:0]),
    .snoop_state_i (snoop_state)
  );

  assign hit            = (rd_state != ST_INVALID) && (rd_tag == addr_q[AW-1:IDX_W]);
  assign o_Bus_Ready    = (state_q == S_IDLE);
  assign o_Action_Valid = act_valid_q;
  assign o_Action       = action_q;
  assign o_Wb_Addr      = wb_addr_q;
  assign o_Wb_Data      = wb_data_q;
  assign o_Probe_State  = probe_state;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q     <= S_IDLE;
      msg_q       <= MSG_NONE;
      addr_q      <= '0;
      act_valid_q <= 1'b0;
      action_q    <= ACT_NONE;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      msg_q       <= msg_d;
      addr_q      <= addr_d;
      act_valid_q <= act_valid_d;
      action_q    <= action_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
    end
  end

  // The action reads the store's pre-edge contents, so a same-cycle local install cannot alter it.
  always_comb begin
    state_d     = state_q;
    msg_d       = msg_q;
    addr_d      = addr_q;
    act_valid_d = act_valid_q;
    action_d    = action_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    snoop_we    = 1'b0;
    snoop_state = ST_INVALID;
    case (state_q)
      S_IDLE: begin
        if (i_Bus_Valid && (i_Bus_Message != 2'd0)) begin
          msg_d   = bus_msg_e'(i_Bus_Message);
          addr_d  = i_Bus_Addr;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        state_d = S_IDLE;
        if (hit) begin
          case (msg_q)
            MSG_READ_MISS: begin
              if (rd_state == ST_MODIFIED) begin
                snoop_we    = 1'b1;
                snoop_state = ST_SHARED;
                action_d    = ACT_WRITEBACK;
                wb_data_d   = rd_data;
              end
            end
            MSG_WRITE_MISS: begin
              snoop_we = 1'b1;
              if (rd_state == ST_MODIFIED) begin
                action_d  = ACT_WRITEBACK;
                wb_data_d = rd_data;
              end
            end
            MSG_INVALIDATE: begin
              snoop_we = 1'b1;
              if (rd_state == ST_MODIFIED) begin
                action_d  = ACT_ABORT;
                wb_data_d = '0;
              end
            end
            default: ;
          endcase
          if (rd_state == ST_MODIFIED && msg_q != MSG_NONE) begin
            act_valid_d = 1'b1;
            wb_addr_d   = addr_q;
            state_d     = S_RESPOND;
          end
        end
      end
      S_RESPOND: begin
        if (i_Action_Ack) begin
          act_valid_d = 1'b0;
          action_d    = ACT_NONE;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_snoop_receiver.sv
// tb/tb_snoop_receiver.sv - directed and randomized bench for snoop_receiver against an array-based MSI model
module tb_snoop_receiver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_Bus_Valid = 1'b0;
  logic [1:0] i_Bus_Message = 2'd0;
  logic [5:0] i_Bus_Addr = 6'd0;
  logic       o_Bus_Ready;
  logic       i_Local_Valid = 1'b0;
  logic [5:0] i_Local_Addr = 6'd0;
  logic [1:0] i_Local_State = 2'd0;
  logic [7:0] i_Local_Data = 8'd0;
  logic       o_Action_Valid;
  logic [1:0] o_Action;
  logic [5:0] o_Wb_Addr;
  logic [7:0] o_Wb_Data;
  logic       i_Action_Ack = 1'b0;
  logic [1:0] i_Probe_Index = 2'd0;
  logic [1:0] o_Probe_State;

  int total = 0;
  int bad = 0;
  int ref_st [4];
  int ref_tag [4];
  int ref_data [4];

  snoop_receiver dut (
    .i_Clock        (clk),
    .i_Reset_n      (rst_n),
    .i_Bus_Valid    (i_Bus_Valid),
    .i_Bus_Message  (i_Bus_Message),
    .i_Bus_Addr     (i_Bus_Addr),
    .o_Bus_Ready    (o_Bus_Ready),
    .i_Local_Valid  (i_Local_Valid),
    .i_Local_Addr   (i_Local_Addr),
    .i_Local_State  (i_Local_State),
    .i_Local_Data   (i_Local_Data),
    .o_Action_Valid (o_Action_Valid),
    .o_Action       (o_Action),
    .o_Wb_Addr      (o_Wb_Addr),
    .o_Wb_Data      (o_Wb_Data),
    .i_Action_Ack   (i_Action_Ack),
    .i_Probe_Index  (i_Probe_Index),
    .o_Probe_State  (o_Probe_State)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    for (int i = 0; i < 4; i++) begin
      ref_st[i] = 0;
      ref_tag[i] = 0;
      ref_data[i] = 0;
    end
  endtask

  task automatic install(input int a, input int st, input int d);
    i_Local_Valid = 1'b1;
    i_Local_Addr  = a[5:0];
    i_Local_State = st[1:0];
    i_Local_Data  = d[7:0];
    step;
    i_Local_Valid = 1'b0;
    ref_st[a % 4] = st;
    ref_tag[a % 4] = a / 4;
    ref_data[a % 4] = d;
  endtask

  task automatic send(input int m, input int a);
    i_Bus_Valid   = 1'b1;
    i_Bus_Message = m[1:0];
    i_Bus_Addr    = a[5:0];
    step;
    i_Bus_Valid   = 1'b0;
    i_Bus_Message = 2'd0;
  endtask

  task automatic get_probe(input int idx, output logic [1:0] st);
    i_Probe_Index = idx[1:0];
    #1;
    st = o_Probe_State;
  endtask

  task automatic test_reset;
    logic [1:0] p;
    rst_n = 1'b0;
    step;
    step;
    total++; if (o_Action_Valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", o_Action_Valid); end
    total++; if (o_Action !== 2'd0) begin bad++; $display("FAIL reset_action got=%0d want=0", o_Action); end
    total++; if (o_Wb_Addr !== 6'd0 || o_Wb_Data !== 8'd0) begin bad++; $display("FAIL reset_wb got=%h/%h want=0/0", o_Wb_Addr, o_Wb_Data); end
    total++; if (o_Bus_Ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", o_Bus_Ready); end
    for (int i = 0; i < 4; i++) begin
      get_probe(i, p);
      total++; if (p !== 2'd0) begin bad++; $display("FAIL reset_probe%0d got=%0d want=0", i, p); end
    end
    rst_n = 1'b1;
    model_reset();
    step;
  endtask

  task automatic test_read_miss_modified;
    logic [1:0] p;
    install(8'h16, 2, 8'hA5);
    total++; if (o_Bus_Ready !== 1'b1) begin bad++; $display("FAIL rm_ready_pre got=%b want=1", o_Bus_Ready); end
    send(1, 8'h16);
    total++; if (o_Bus_Ready !== 1'b0) begin bad++; $display("FAIL rm_ready_lookup got=%b want=0", o_Bus_Ready); end
    step;
    total++; if (o_Action_Valid !== 1'b1 || o_Action !== 2'd1) begin bad++; $display("FAIL rm_action got=%b/%0d want=1/1", o_Action_Valid, o_Action); end
    total++; if (o_Wb_Addr !== 6'h16 || o_Wb_Data !== 8'hA5) begin bad++; $display("FAIL rm_wb got=%h/%h want=16/a5", o_Wb_Addr, o_Wb_Data); end
    total++; if (o_Bus_Ready !== 1'b0) begin bad++; $display("FAIL rm_ready_respond got=%b want=0", o_Bus_Ready); end
    get_probe(2, p);
    total++; if (p !== 2'd1) begin bad++; $display("FAIL rm_probe got=%0d want=1", p); end
    ref_st[2] = 1;
    i_Action_Ack = 1'b1;
    step;
    i_Action_Ack = 1'b0;
    total++; if (o_Action_Valid !== 1'b0 || o_Action !== 2'd0 || o_Bus_Ready !== 1'b1) begin bad++; $display("FAIL rm_ack got=%b/%0d/%b want=0/0/1", o_Action_Valid, o_Action, o_Bus_Ready); end
  endtask

  task automatic test_invalidate_shared;
    logic [1:0] p;
    install(8'h16, 1, 8'h11);
    send(3, 8'h16);
    step;
    total++; if (o_Action_Valid !== 1'b0) begin bad++; $display("FAIL inv_sh_valid got=%b want=0", o_Action_Valid); end
    total++; if (o_Bus_Ready !== 1'b1) begin bad++; $display("FAIL inv_sh_ready got=%b want=1", o_Bus_Ready); end
    get_probe(2, p);
    total++; if (p !== 2'd0) begin bad++; $display("FAIL inv_sh_probe got=%0d want=0", p); end
    ref_st[2] = 0;
  endtask

  task automatic test_tag_miss;
    logic [1:0] p;
    install(8'h16, 1, 8'h22);
    send(2, 8'h26);
    step;
    total++; if (o_Action_Valid !== 1'b0 || o_Bus_Ready !== 1'b1) begin bad++; $display("FAIL miss_out got=%b/%b want=0/1", o_Action_Valid, o_Bus_Ready); end
    get_probe(2, p);
    total++; if (p !== 2'd1) begin bad++; $display("FAIL miss_probe got=%0d want=1", p); end
  endtask

  task automatic test_abort_hold;
    logic [1:0] p;
    install(8'h16, 2, 8'hA5);
    send(3, 8'h16);
    step;
    total++; if (o_Action_Valid !== 1'b1 || o_Action !== 2'd2 || o_Wb_Data !== 8'h00) begin bad++; $display("FAIL abort_out got=%b/%0d/%h want=1/2/00", o_Action_Valid, o_Action, o_Wb_Data); end
    get_probe(2, p);
    total++; if (p !== 2'd0) begin bad++; $display("FAIL abort_probe got=%0d want=0", p); end
    ref_st[2] = 0;
    for (int c = 0; c < 5; c++) begin
      step;
      total++;
      if (o_Action_Valid !== 1'b1 || o_Action !== 2'd2 || o_Wb_Addr !== 6'h16 || o_Wb_Data !== 8'h00 || o_Bus_Ready !== 1'b0) begin
        bad++; $display("FAIL abort_hold%0d got=%b/%0d/%h/%h/%b want=1/2/16/00/0", c, o_Action_Valid, o_Action, o_Wb_Addr, o_Wb_Data, o_Bus_Ready);
      end
    end
    i_Action_Ack = 1'b1;
    step;
    i_Action_Ack = 1'b0;
    total++; if (o_Action_Valid !== 1'b0 || o_Bus_Ready !== 1'b1) begin bad++; $display("FAIL abort_ack got=%b/%b want=0/1", o_Action_Valid, o_Bus_Ready); end
  endtask

  task automatic test_early_ack;
    install(8'h2D, 2, 8'h77);
    i_Action_Ack = 1'b1;
    step;
    send(1, 8'h2D);
    step;
    total++; if (o_Action_Valid !== 1'b1 || o_Wb_Data !== 8'h77) begin bad++; $display("FAIL early_ack got=%b/%h want=1/77", o_Action_Valid, o_Wb_Data); end
    ref_st[1] = 1;
    step;
    i_Action_Ack = 1'b0;
    total++; if (o_Action_Valid !== 1'b0 || o_Bus_Ready !== 1'b1) begin bad++; $display("FAIL early_ack_drop got=%b/%b want=0/1", o_Action_Valid, o_Bus_Ready); end
  endtask

  task automatic test_collision;
    logic [1:0] p;
    install(8'h16, 2, 8'hA5);
    send(2, 8'h16);
    i_Local_Valid = 1'b1;
    i_Local_Addr  = 6'h16;
    i_Local_State = 2'd2;
    i_Local_Data  = 8'h3C;
    step;
    i_Local_Valid = 1'b0;
    ref_st[2] = 2;
    ref_data[2] = 8'h3C;
    total++; if (o_Action !== 2'd1 || o_Wb_Data !== 8'hA5) begin bad++; $display("FAIL coll_action got=%0d/%h want=1/a5", o_Action, o_Wb_Data); end
    get_probe(2, p);
    total++; if (p !== 2'd2) begin bad++; $display("FAIL coll_probe got=%0d want=2", p); end
    i_Action_Ack = 1'b1;
    step;
    i_Action_Ack = 1'b0;
  endtask

  task automatic test_reset_respond;
    logic [1:0] p;
    install(8'h16, 2, 8'h5A);
    send(1, 8'h16);
    step;
    total++; if (o_Action_Valid !== 1'b1) begin bad++; $display("FAIL rr_pre got=%b want=1", o_Action_Valid); end
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (o_Action_Valid !== 1'b0 || o_Action !== 2'd0 || o_Bus_Ready !== 1'b1) begin bad++; $display("FAIL rr_out got=%b/%0d/%b want=0/0/1", o_Action_Valid, o_Action, o_Bus_Ready); end
    for (int i = 0; i < 4; i++) begin
      get_probe(i, p);
      total++; if (p !== 2'd0) begin bad++; $display("FAIL rr_probe%0d got=%0d want=0", i, p); end
    end
    step;
    rst_n = 1'b1;
    model_reset();
    step;
  endtask

  task automatic test_random;
    logic [1:0] p;
    int idx, tag, a, m, st, d, exp_act, exp_data, delay;
    int lidx_tag, lst, ld;
    bit coll;
    for (int n = 0; n < 300; n++) begin
      idx = $urandom_range(0, 3);
      tag = ($urandom_range(0, 1) != 0) ? 5 : 9;
      a = tag * 4 + idx;
      if ($urandom_range(0, 2) == 0) begin
        st = $urandom_range(0, 2);
        d = $urandom_range(0, 255);
        install(a, st, d);
      end else begin
        m = $urandom_range(0, 3);
        total++; if (o_Bus_Ready !== 1'b1) begin bad++; $display("FAIL rnd_ready_pre n=%0d got=%b want=1", n, o_Bus_Ready); end
        send(m, a);
        if (m == 0) begin
          total++; if (o_Bus_Ready !== 1'b1) begin bad++; $display("FAIL rnd_msg0 n=%0d got=%b want=1", n, o_Bus_Ready); end
        end else begin
          coll = ($urandom_range(0, 3) == 0);
          lidx_tag = ($urandom_range(0, 1) != 0) ? 5 : 9;
          lst = $urandom_range(0, 2);
          ld = $urandom_range(0, 255);
          if (coll) begin
            i_Local_Valid = 1'b1;
            i_Local_Addr  = 6'(lidx_tag * 4 + idx);
            i_Local_State = lst[1:0];
            i_Local_Data  = ld[7:0];
          end
          exp_act = 0;
          exp_data = 0;
          if (ref_st[idx] != 0 && ref_tag[idx] == tag) begin
            if (ref_st[idx] == 2) begin
              exp_act = (m == 3) ? 2 : 1;
              exp_data = (m == 3) ? 0 : ref_data[idx];
              ref_st[idx] = (m == 1) ? 1 : 0;
            end else if (m != 1) begin
              ref_st[idx] = 0;
            end
          end
          if (coll) begin
            ref_st[idx] = lst;
            ref_tag[idx] = lidx_tag;
            ref_data[idx] = ld;
          end
          step;
          i_Local_Valid = 1'b0;
          total++; if (o_Action_Valid !== (exp_act != 0) || o_Action !== exp_act[1:0]) begin bad++; $display("FAIL rnd_action n=%0d got=%b/%0d want=%0d", n, o_Action_Valid, o_Action, exp_act); end
          total++; if (o_Bus_Ready !== (exp_act == 0)) begin bad++; $display("FAIL rnd_ready n=%0d got=%b want=%0d", n, o_Bus_Ready, exp_act == 0); end
          get_probe(idx, p);
          total++; if (p !== ref_st[idx][1:0]) begin bad++; $display("FAIL rnd_probe n=%0d got=%0d want=%0d", n, p, ref_st[idx]); end
          if (exp_act != 0) begin
            total++; if (o_Wb_Addr !== a[5:0] || o_Wb_Data !== exp_data[7:0]) begin bad++; $display("FAIL rnd_wb n=%0d got=%h/%h want=%h/%h", n, o_Wb_Addr, o_Wb_Data, a, exp_data); end
            delay = $urandom_range(0, 3);
            for (int c = 0; c < delay; c++) begin
              step;
              total++; if (o_Action_Valid !== 1'b1 || o_Action !== exp_act[1:0]) begin bad++; $display("FAIL rnd_hold n=%0d got=%b/%0d want=1/%0d", n, o_Action_Valid, o_Action, exp_act); end
            end
            i_Action_Ack = 1'b1;
            step;
            i_Action_Ack = 1'b0;
            total++; if (o_Action_Valid !== 1'b0 || o_Bus_Ready !== 1'b1) begin bad++; $display("FAIL rnd_ack n=%0d got=%b/%b want=0/1", n, o_Action_Valid, o_Bus_Ready); end
          end
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      get_probe(i, p);
      total++; if (p !== ref_st[i][1:0]) begin bad++; $display("FAIL rnd_final%0d got=%0d want=%0d", i, p, ref_st[i]); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_read_miss_modified();
    test_invalidate_shared();
    test_tag_miss();
    test_abort_hold();
    test_early_ack();
    test_collision();
    test_reset_respond();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
